// File: rtl/jsilicon_pkg.sv
// Shared definitions for the fetch/decode sequencer and the register-file stage.
package jsilicon_pkg;

    localparam int unsigned OPCODE_W  = 3;
    localparam int unsigned OPERAND_W = 5;
    localparam int unsigned INSN_W    = OPCODE_W + OPERAND_W;

    localparam logic [INSN_W-1:0] HALT_INSN = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_HALT
    } fd_state_t;

    // Opcode encodings understood by the register-file stage.
    localparam logic [OPCODE_W-1:0] OP_NOP  = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_AND  = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_OR   = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_SYS  = 3'd7;

    function automatic logic is_halt(input logic [INSN_W-1:0] insn);
        return insn == HALT_INSN;
    endfunction

endpackage

// File: rtl/insn_buffer.sv
// DEPTH x 8 instruction store: one synchronous write port, one combinational
// read port; reset fills every entry with HALT_INSN.
module insn_buffer
    import jsilicon_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [INSN_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [INSN_W-1:0] rdata_o
);

    logic [INSN_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: HALT_INSN};
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_decode.sv
// In-order instruction sequencer feeding the register file: FETCH/DECODE/ISSUE
// FSM with a registered one-cycle ena per instruction and hold back-pressure.
// Define FETCH_DECODE_LOOP_EN to wrap pc from DEPTH-1 to 0 instead of halting.
module fetch_decode
    import jsilicon_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [INSN_W-1:0]    prog_data,
    input  logic                 start,
    input  logic                 hold,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [OPERAND_W-1:0] operand,
    output logic                 ena,
    output logic [AW-1:0]        pc,
    output logic                 busy,
    output logic                 halted
);

    fd_state_t              state_q, state_d;
    logic [AW-1:0]          pc_q, pc_d;
    logic [INSN_W-1:0]      ir_q, ir_d;
    logic [OPCODE_W-1:0]    opcode_q, opcode_d;
    logic [OPERAND_W-1:0]   operand_q, operand_d;
    logic                   ena_q, ena_d;
    logic [INSN_W-1:0]      buf_rdata;
    logic                   busy_w;

    assign busy_w = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_ISSUE);

    insn_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .we_i    (prog_we && !busy_w),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            ena_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            ena_q     <= ena_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        ena_d     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = buf_rdata;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_halt(ir_q)) begin
                    state_d = ST_HALT;
                end else begin
                    opcode_d  = ir_q[OPERAND_W +: OPCODE_W];
                    operand_d = ir_q[OPERAND_W-1:0];
                    state_d   = ST_ISSUE;
                    ena_d     = !hold;
                end
            end
            ST_ISSUE: begin
                // ena_q already carries last cycle's hold sample; it alone decides
                // whether this ISSUE cycle is the issuing one.
                if (ena_q) begin
                    if (pc_q == AW'(DEPTH - 1)) begin
`ifdef FETCH_DECODE_LOOP_EN
                        pc_d    = '0;
                        state_d = ST_FETCH;
`else
                        state_d = ST_HALT;
`endif
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = ST_FETCH;
                    end
                end else begin
                    ena_d = !hold;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign opcode  = opcode_q;
    assign operand = operand_q;
    assign ena     = ena_q;
    assign pc      = pc_q;
    assign busy    = busy_w;
    assign halted  = (state_q == ST_HALT);

endmodule
